// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - ROM port, redirect and instruction output bundle of the fetch sequencer
interface fetch_sequencer_if;
   logic [15:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [15:0] inst_pc;
   logic        inst_ready;

   modport master (
      output rom_addr,
      input  rom_data,
      input  redirect,
      input  redirect_pc,
      output inst_valid,
      output inst,
      output inst_pc,
      input  inst_ready
   );

   modport slave (
      input  rom_addr,
      output rom_data,
      output redirect,
      output redirect_pc,
      input  inst_valid,
      input  inst,
      input  inst_pc,
      output inst_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with single-entry output stage, redirect and halt
module fetch_sequencer (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   fetch_sequencer_if.master        bus,
   output logic                     halted,
   output logic [15:0]              fetch_count
);
   localparam logic [31:0] HALT_WORD = 32'hD60003E0;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

   state_t      state, state_nx;
   logic [15:0] pc, pc_nx;
   logic        valid, valid_nx;
   logic [31:0] inst_q, inst_nx;
   logic [15:0] ipc, ipc_nx;
   logic [15:0] cnt_nx;
   logic        active;
   logic        capture;
   logic        accept;

   // Redirect dominates both capture and acceptance; it is ignored only in IDLE.
   always_comb begin
      active  = (state != S_IDLE);
      accept  = active && valid && bus.inst_ready && !bus.redirect;
      capture = (state == S_FETCH) && (!valid || bus.inst_ready) && !bus.redirect;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         pc          <= 16'd0;
         valid       <= 1'b0;
         inst_q      <= 32'd0;
         ipc         <= 16'd0;
         fetch_count <= 16'd0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         valid       <= valid_nx;
         inst_q      <= inst_nx;
         ipc         <= ipc_nx;
         fetch_count <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      valid_nx = valid;
      inst_nx  = inst_q;
      ipc_nx   = ipc;
      cnt_nx   = fetch_count;

      if (accept && (fetch_count != 16'hFFFF))
         cnt_nx = fetch_count + 16'd1;

      case (state)
         S_IDLE: begin
            if (start) begin
               pc_nx    = 16'd0;
               state_nx = S_FETCH;
            end
         end
         S_FETCH, S_HALT: begin
            if (bus.redirect) begin
               valid_nx = 1'b0;
               pc_nx    = bus.redirect_pc;
               state_nx = S_FETCH;
            end else if (capture) begin
               inst_nx  = bus.rom_data;
               ipc_nx   = pc;
               valid_nx = 1'b1;
               pc_nx    = pc + 16'd1;
               // The halt word itself is still delivered to decode.
               if (bus.rom_data == HALT_WORD)
                  state_nx = S_HALT;
            end else if (valid && bus.inst_ready) begin
               valid_nx = 1'b0;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   assign bus.rom_addr   = pc;
   assign bus.inst_valid = valid;
   assign bus.inst       = inst_q;
   assign bus.inst_pc    = ipc;
   assign halted         = (state == S_HALT) && !valid;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer with a behavioural reference model
module tb_fetch_sequencer;
   localparam logic [31:0] HALT_WORD = 32'hD60003E0;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        halted;
   logic [15:0] fetch_count;

   fetch_sequencer_if bus();

   fetch_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .bus         (bus),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   function automatic logic [31:0] rom_word(input logic [15:0] a);
      if (a == 16'd0)
         return 32'hD2800021;
      else if (a == 16'd10)
         return HALT_WORD;
      else
         return {a ^ 16'h5A5A, a};
   endfunction

   assign bus.rom_data = rom_word(bus.rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   // Reference model: mode 0 = waiting for start, 1 = fetching, 2 = stopped on halt word.
   bit          m_known = 1'b0;
   int          m_mode;
   logic [15:0] m_pc;
   bit          m_valid;
   logic [31:0] m_inst;
   logic [15:0] m_ipc;
   logic [15:0] m_cnt;

   task automatic model_step();
      logic [31:0] w;
      bit          took;
      if (reset) begin
         m_known = 1'b1;
         m_mode  = 0;
         m_pc    = 16'd0;
         m_valid = 1'b0;
         m_inst  = 32'd0;
         m_ipc   = 16'd0;
         m_cnt   = 16'd0;
      end else if (!m_known) begin
         m_known = 1'b0;
      end else if (m_mode == 0) begin
         if (start) begin
            m_mode = 1;
            m_pc   = 16'd0;
         end
      end else if (bus.redirect) begin
         m_valid = 1'b0;
         m_pc    = bus.redirect_pc;
         m_mode  = 1;
      end else begin
         took = m_valid && bus.inst_ready;
         if (took && m_cnt != 16'hFFFF)
            m_cnt = m_cnt + 16'd1;
         if (m_mode == 1 && (!m_valid || bus.inst_ready)) begin
            w       = rom_word(m_pc);
            m_inst  = w;
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd1;
            if (w == HALT_WORD)
               m_mode = 2;
         end else if (took) begin
            m_valid = 1'b0;
         end
      end
   endtask

   // Inputs only change just after a rising edge, so at the falling edge they hold the values the next edge samples.
   initial forever begin
      @(negedge clock);
      if (m_known) begin
         chk("rom_addr",    32'(bus.rom_addr),   32'(m_pc));
         chk("inst_valid",  32'(bus.inst_valid), 32'(m_valid));
         chk("inst",        bus.inst,            m_inst);
         chk("inst_pc",     32'(bus.inst_pc),    32'(m_ipc));
         chk("halted",      32'(halted),         32'(m_mode == 2 && !m_valid));
         chk("fetch_count", 32'(fetch_count),    32'(m_cnt));
      end
      model_step();
   end

   initial begin
      int n;
      bit seen;
      logic [15:0] tgt;

      reset           = 1'b1;
      start           = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 16'd0;
      bus.inst_ready  = 1'b1;
      repeat (2) cycle();
      chk("reset inst_valid",  32'(bus.inst_valid), 32'd0);
      chk("reset rom_addr",    32'(bus.rom_addr),   32'd0);
      chk("reset fetch_count", 32'(fetch_count),    32'd0);
      chk("reset halted",      32'(halted),         32'd0);
      reset = 1'b0;
      cycle();

      start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      chk("first inst",    bus.inst,            32'hD2800021);
      chk("first inst_pc", 32'(bus.inst_pc),    32'd0);
      cycle();
      chk("seq inst_pc 1", 32'(bus.inst_pc),    32'd1);
      cycle();
      chk("seq inst_pc 2", 32'(bus.inst_pc),    32'd2);

      bus.inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stall inst_pc",  32'(bus.inst_pc),  32'd2);
         chk("stall inst",     bus.inst,          32'h5A580002);
         chk("stall rom_addr", 32'(bus.rom_addr), 32'd3);
      end
      bus.inst_ready = 1'b1;
      cycle();
      chk("release inst_pc", 32'(bus.inst_pc), 32'd3);
      chk("release count",   32'(fetch_count), 32'd3);

      repeat (6) cycle();
      chk("pre-redirect inst_pc", 32'(bus.inst_pc), 32'd9);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0003;
      cycle();
      bus.redirect = 1'b0;
      chk("redirect bubble",  32'(bus.inst_valid), 32'd0);
      chk("redirect count",   32'(fetch_count),    32'd9);
      cycle();
      chk("redirect valid",   32'(bus.inst_valid), 32'd1);
      chk("redirect inst_pc", 32'(bus.inst_pc),    32'd3);

      n    = 0;
      seen = 1'b0;
      while (!halted && n < 40) begin
         if (bus.inst_valid && bus.inst == HALT_WORD && bus.inst_pc == 16'd10)
            seen = 1'b1;
         cycle();
         n++;
      end
      chk("halt reached",     32'(n < 40),          32'd1);
      chk("halt word seen",   32'(seen),            32'd1);
      chk("halt rom_addr",    32'(bus.rom_addr),    32'd11);
      chk("halt inst_valid",  32'(bus.inst_valid),  32'd0);
      chk("halt count",       32'(fetch_count),     32'd17);
      repeat (3) cycle();
      start = 1'b1;
      cycle();
      start = 1'b0;
      chk("halt ignores start", 32'(halted),       32'd1);
      chk("halt rom_addr held", 32'(bus.rom_addr), 32'd11);

      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0000;
      cycle();
      bus.redirect = 1'b0;
      chk("resume halted",  32'(halted), 32'd0);
      cycle();
      chk("resume inst_pc", 32'(bus.inst_pc), 32'd0);
      chk("resume inst",    bus.inst,         32'hD2800021);

      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'hFFFF;
      cycle();
      bus.redirect = 1'b0;
      cycle();
      chk("wrap inst_pc ffff", 32'(bus.inst_pc), 32'h0000FFFF);
      cycle();
      chk("wrap inst_pc 0",    32'(bus.inst_pc), 32'd0);
      chk("wrap valid",        32'(bus.inst_valid), 32'd1);

      reset           = 1'b1;
      start           = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0005;
      cycle();
      reset        = 1'b0;
      start        = 1'b0;
      bus.redirect = 1'b0;
      chk("midreset inst_valid",  32'(bus.inst_valid), 32'd0);
      chk("midreset fetch_count", 32'(fetch_count),    32'd0);
      chk("midreset rom_addr",    32'(bus.rom_addr),   32'd0);
      chk("midreset halted",      32'(halted),         32'd0);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0007;
      cycle();
      bus.redirect = 1'b0;
      repeat (2) cycle();
      chk("idle ignores redirect", 32'(bus.rom_addr),   32'd0);
      chk("idle stays empty",      32'(bus.inst_valid), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 9) == 0);
         bus.redirect = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 3))
            0:       tgt = 16'($urandom_range(0, 12));
            1:       tgt = 16'hFFFF - 16'($urandom_range(0, 3));
            2:       tgt = 16'($urandom);
            default: tgt = 16'($urandom_range(5, 10));
         endcase
         bus.redirect_pc = tgt;
         bus.inst_ready  = ($urandom_range(0, 3) != 0);
         cycle();
      end
      reset        = 1'b0;
      start        = 1'b0;
      bus.redirect = 1'b0;
      repeat (2) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
